// File: rtl/ddc_readout_pkg.sv
// Shared types and constants for the DDC event readout path.
package ddc_readout_pkg;

  localparam int DDC_DEPTH  = 16;
  localparam int DDC_PEAK_W = 32;
  localparam int DDC_TAIL_W = 32;
  localparam int DDC_TIME_W = 24;
  localparam int DDC_OVF_W  = 8;

  // Bit positions inside ddc_time_out = {valid, seq, time}
  localparam int VALID_BIT = DDC_TIME_W + 1;
  localparam int SEQ_BIT   = DDC_TIME_W;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

endpackage

// File: rtl/ddc_evt_fifo.sv
// Synchronous 1R1W event FIFO with registered read data and an explicit occupancy counter.
module ddc_evt_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 88
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wr_data,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [W-1:0]  rd_data_r;

  // Storage array; contents are don't-care until written, so it carries no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and read register; a full FIFO may push and pop in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      level_r   <= {LW{1'b0}};
      rd_data_r <= {W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_data_r <= mem_r[rd_ptr_r];
        rd_ptr_r  <= rd_ptr_r + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign rd_data = rd_data_r;
  assign level   = level_r;

endmodule

// File: rtl/ddc_readout_ctrl.sv
// Queues DDC pulse events and presents them one at a time to the HPS over PIO,
// advancing on each toggle of hps_read_bit.
module ddc_readout_ctrl
  import ddc_readout_pkg::*;
#(
  parameter int DEPTH  = DDC_DEPTH,
  parameter int PEAK_W = DDC_PEAK_W,
  parameter int TAIL_W = DDC_TAIL_W,
  parameter int TIME_W = DDC_TIME_W,
  parameter int OVF_W  = DDC_OVF_W
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic                     capture_en,
  input  logic                     evt_valid,
  input  logic [PEAK_W-1:0]        evt_peak,
  input  logic [TAIL_W-1:0]        evt_tail,
  input  logic [TIME_W-1:0]        evt_time,
  input  logic                     hps_read_bit,
  output logic [PEAK_W-1:0]        ddc_peak_out,
  output logic [TAIL_W-1:0]        ddc_tail_out,
  output logic [TIME_W+1:0]        ddc_time_out,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [OVF_W-1:0]         ovf_count
);

  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int EVT_W = PEAK_W + TAIL_W + TIME_W;

  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (v == {OVF_W{1'b1}}) ? v : v + OVF_W'(1);
  endfunction

  state_t           state_r;
  state_t           next_state_s;
  logic             ack_ref_r;
  logic             valid_r;
  logic             seq_cnt_r;
  logic             seq_out_r;
  logic [OVF_W-1:0] ovf_r;

  logic             ack_s;
  logic             want_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic [LW-1:0]    level_s;
  logic [LW-1:0]    level_next_s;
  logic [EVT_W-1:0] head_s;

  assign ack_s  = hps_read_bit ^ ack_ref_r;
  assign want_s = evt_valid & capture_en;
  assign full_s = (level_s == LW'(DEPTH));
  assign pop_s  = (state_r == ST_FETCH);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken
  assign push_s = want_s & (~full_s | pop_s);
  assign drop_s = want_s & full_s & ~pop_s;
  assign level_next_s = level_s + LW'(push_s) - LW'(pop_s);

  ddc_evt_fifo #(
    .DEPTH (DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data ({evt_peak, evt_tail, evt_time}),
    .rd_data (head_s),
    .level   (level_s)
  );

  // Next-state decode for the presentation FSM
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (level_s != {LW{1'b0}}) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_EMPTY;
        end
      end
      ST_FETCH: begin
        next_state_s = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (!ack_s) begin
          next_state_s = ST_PRESENT;
        end else if (level_next_s != {LW{1'b0}}) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_EMPTY;
        end
      end
      default: begin
        next_state_s = ST_EMPTY;
      end
    endcase
  end

  // State, ack reference, valid/seq presentation and overflow counter
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_r   <= ST_EMPTY;
      ack_ref_r <= hps_read_bit;
      valid_r   <= 1'b0;
      seq_cnt_r <= 1'b0;
      seq_out_r <= 1'b0;
      ovf_r     <= {OVF_W{1'b0}};
    end else begin
      state_r   <= next_state_s;
      ack_ref_r <= hps_read_bit;
      valid_r   <= (next_state_s == ST_PRESENT);
      if (pop_s) begin
        seq_out_r <= seq_cnt_r;
        seq_cnt_r <= ~seq_cnt_r;
      end
      if (drop_s) begin
        ovf_r <= sat_inc(ovf_r);
      end
    end
  end

  // Field registers live in the FIFO read port and only change on the pop edge
  assign ddc_peak_out = head_s[EVT_W-1 -: PEAK_W];
  assign ddc_tail_out = head_s[TAIL_W+TIME_W-1 -: TAIL_W];
  assign ddc_time_out = {valid_r, seq_out_r, head_s[TIME_W-1:0]};
  assign fifo_level   = level_s;
  assign ovf_count    = ovf_r;

endmodule

// File: tb/tb_ddc_readout_ctrl.sv
// Randomised scoreboard bench for ddc_readout_ctrl against a queue-based behavioural model.
module tb_ddc_readout_ctrl;
  import ddc_readout_pkg::*;

  localparam int D = 16;

  typedef struct {
    logic [31:0] peak;
    logic [31:0] tail;
    logic [23:0] tm;
  } evt_t;

  typedef struct {
    logic [31:0] peak;
    logic [31:0] tail;
    logic [23:0] tm;
    bit          seq;
  } exp_t;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        capture_en = 1'b0;
  logic        evt_valid = 1'b0;
  logic [31:0] evt_peak = 32'd0;
  logic [31:0] evt_tail = 32'd0;
  logic [23:0] evt_time = 24'd0;
  logic        hps_read_bit = 1'b0;
  logic [31:0] ddc_peak_out;
  logic [31:0] ddc_tail_out;
  logic [25:0] ddc_time_out;
  logic [4:0]  fifo_level;
  logic [7:0]  ovf_count;

  always #5 clk_clk = ~clk_clk;

  ddc_readout_ctrl dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .capture_en    (capture_en),
    .evt_valid     (evt_valid),
    .evt_peak      (evt_peak),
    .evt_tail      (evt_tail),
    .evt_time      (evt_time),
    .hps_read_bit  (hps_read_bit),
    .ddc_peak_out  (ddc_peak_out),
    .ddc_tail_out  (ddc_tail_out),
    .ddc_time_out  (ddc_time_out),
    .fifo_level    (fifo_level),
    .ovf_count     (ovf_count)
  );

  int   vecs = 0;
  int   errs = 0;
  int   ncyc = 0;
  evt_t mq[$];
  exp_t exp_q[$];
  bit   m_valid = 1'b0;
  bit   m_seq = 1'b0;
  bit   m_ref = 1'b0;
  int   m_pop_at = -1;
  int   m_ovf = 0;
  bit   hps_v = 1'b0;
  int   max_lvl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Reference behaviour for one clock edge, in terms of a queue and a scheduled pop time
  task automatic model_edge(input bit rst_n, input bit ev, input bit cap,
                            input logic [31:0] pk, input logic [31:0] tl, input logic [23:0] tm);
    int  pre;
    bit  ack;
    bit  pop_now;
    evt_t e;
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      m_valid = 1'b0;
      m_seq = 1'b0;
      m_ref = hps_v;
      m_pop_at = -1;
      m_ovf = 0;
    end else begin
      pre = mq.size();
      ack = (hps_v != m_ref);
      m_ref = hps_v;
      pop_now = (m_pop_at == ncyc);
      if (pop_now) begin
        e = mq.pop_front();
        exp_q.push_back('{e.peak, e.tail, e.tm, m_seq});
        m_seq = ~m_seq;
        m_valid = 1'b1;
        m_pop_at = -1;
      end
      if (ev && cap) begin
        if (pre < D || pop_now) mq.push_back('{pk, tl, tm});
        else if (m_ovf < 255) m_ovf++;
      end
      if (!pop_now) begin
        if (m_valid && ack) begin
          m_valid = 1'b0;
          if (mq.size() > 0) m_pop_at = ncyc + 1;
        end else if (!m_valid && m_pop_at < 0 && pre > 0) begin
          m_pop_at = ncyc + 1;
        end
      end
    end
  endtask

  task automatic cyc(input bit rst_n, input bit ev, input bit cap,
                     input logic [31:0] pk, input logic [31:0] tl, input logic [23:0] tm);
    reset_reset_n = rst_n;
    evt_valid = ev;
    capture_en = cap;
    evt_peak = pk;
    evt_tail = tl;
    evt_time = tm;
    hps_read_bit = hps_v;
    @(posedge clk_clk);
    model_edge(rst_n, ev, cap, pk, tl, tm);
    ncyc++;
    @(negedge clk_clk);
    chk("valid", 64'(ddc_time_out[VALID_BIT]), 64'(m_valid));
    chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
    chk("ovf_count", 64'(ovf_count), 64'(m_ovf));
    if (!rst_n) begin
      chk("reset_peak", 64'(ddc_peak_out), 64'd0);
      chk("reset_tail", 64'(ddc_tail_out), 64'd0);
      chk("reset_time", 64'(ddc_time_out), 64'd0);
    end
    if (64'(fifo_level) > 64'(max_lvl)) max_lvl = int'(fifo_level);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 24'd0);
  endtask

  task automatic push_rnd();
    cyc(1'b1, 1'b1, 1'b1, $urandom, $urandom, 24'($urandom));
  endtask

  task automatic drain();
    for (int i = 0; i < 6 * D; i++) begin
      if (m_valid) hps_v = ~hps_v;
      idle(1);
    end
  endtask

  // Scoreboard monitor: each new presentation is matched against the oldest expected event
  bit prev_v = 1'b0;
  bit prev_s = 1'b0;
  always @(negedge clk_clk) begin
    exp_t e;
    if (ddc_time_out[VALID_BIT] && (!prev_v || ddc_time_out[SEQ_BIT] != prev_s)) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_event: got peak 0x%0h with no event expected", ddc_peak_out);
      end else begin
        e = exp_q.pop_front();
        chk("sb_peak", 64'(ddc_peak_out), 64'(e.peak));
        chk("sb_tail", 64'(ddc_tail_out), 64'(e.tail));
        chk("sb_time", 64'(ddc_time_out[23:0]), 64'(e.tm));
        chk("sb_seq", 64'(ddc_time_out[SEQ_BIT]), 64'(e.seq));
      end
    end
    prev_v = ddc_time_out[VALID_BIT];
    prev_s = ddc_time_out[SEQ_BIT];
  end

  initial begin
    max_lvl = 0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 24'd0);

    // Single event: latency and encoding of the time word
    cyc(1'b1, 1'b1, 1'b1, 32'h1234, 32'hABCD, 24'h000100);
    idle(2);
    chk("t1_time_word", 64'(ddc_time_out), 64'h2000100);
    chk("t1_peak", 64'(ddc_peak_out), 64'h1234);
    hps_v = ~hps_v;
    idle(1);
    chk("t1_ack_clears_valid", 64'(ddc_time_out[VALID_BIT]), 64'd0);
    idle(2);

    // Burst of three with an HPS acking each one
    max_lvl = 0;
    for (int i = 0; i < 3; i++) push_rnd();
    for (int i = 0; i < 20; i++) begin
      if (m_valid) hps_v = ~hps_v;
      idle(1);
    end
    chk("t2_level_peak", 64'(max_lvl), 64'd2);

    // Spurious ack while empty, then a normal event
    hps_v = ~hps_v;
    idle(2);
    push_rnd();
    idle(3);
    chk("t4_presented", 64'(ddc_time_out[VALID_BIT]), 64'd1);
    drain();

    // Capture disabled: pulses are ignored and not counted
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, $urandom, $urandom, 24'($urandom));
    chk("t5_level", 64'(fifo_level), 64'd0);
    chk("t5_ovf", 64'(ovf_count), 64'd0);

    // Overfill with no acks
    for (int i = 0; i < D + 3; i++) push_rnd();
    chk("t3_level_full", 64'(fifo_level), 64'(D));
    chk("t3_ovf", 64'(ovf_count), 64'd2);

    // Ack while full, then push during the fetch cycle: accepted, no drop
    hps_v = ~hps_v;
    idle(1);
    push_rnd();
    chk("full_push_on_pop_level", 64'(fifo_level), 64'(D));
    chk("full_push_on_pop_ovf", 64'(ovf_count), 64'd2);

    // Drive the overflow counter into saturation
    for (int i = 0; i < 260; i++) push_rnd();
    chk("ovf_saturated", 64'(ovf_count), 64'hFF);
    for (int i = 0; i < 5; i++) push_rnd();
    chk("ovf_stays_saturated", 64'(ovf_count), 64'hFF);

    // Reset while presenting with four queued; ack line moves during reset
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 24'd0);
    for (int i = 0; i < 5; i++) push_rnd();
    idle(1);
    chk("t6_queued", 64'(fifo_level), 64'd4);
    hps_v = ~hps_v;
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 24'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 24'd0);
    push_rnd();
    idle(4);
    chk("t6_no_false_ack", 64'(ddc_time_out[VALID_BIT]), 64'd1);
    drain();

    // Random traffic with random acks, spurious toggles and occasional resets
    for (int i = 0; i < 1500; i++) begin
      bit rn;
      rn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) hps_v = ~hps_v;
      cyc(rn, ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) != 0),
          $urandom, $urandom, 24'($urandom));
    end
    drain();
    idle(3);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
